// File: rtl/imem_responder_if.sv
// Fetch-path bundle between the fetch stage (master) and the instruction
// memory responder (slave): request handshake plus response handshake.
interface imem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [31:0] rsp_pc;
   logic        rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_pc, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_pc, rsp_err
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one word fetch at a time, waits
// WAIT_STATES cycles, then presents the word (or an error) until consumed.
// The word array is loaded through a side write port and is never cleared
// by reset.
module imem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   imem_responder_if.slave       bus,
   input  logic                  load_en,
   input  logic [31:0]           load_addr,
   input  logic [31:0]           load_data
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Misaligned, below the base, or past the end of the array. The offset is
   // compared in 33 bits so the array end may sit at the top of the space.
   function automatic logic addr_err(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
   endfunction

   // Word index of a byte address, truncated to the array index width.
   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   logic [31:0]      mem [DEPTH_WORDS];

   state_t           state_r;
   state_t           state_nxt_s;
   logic [2:0]       cnt_r;
   logic [2:0]       cnt_nxt_s;
   logic             rsp_valid_r;
   logic             rsp_valid_nxt_s;
   logic [31:0]      rsp_data_r;
   logic [31:0]      rsp_pc_r;
   logic             rsp_err_r;
   logic [IDX_W-1:0] pend_idx_r;
   logic             pend_err_r;

   logic             req_ready_s;
   logic             accept_s;
   logic             req_err_s;
   logic [IDX_W-1:0] req_idx_s;
   logic             rd_en_s;
   logic [IDX_W-1:0] rd_idx_s;
   logic             rd_err_s;

   // Request-side decode: readiness depends only on state and rsp_ready.
   always_comb begin
      req_ready_s = reset_n && ((state_r == IDLE) || ((state_r == RESP) && bus.rsp_ready));
      accept_s    = bus.req_valid && req_ready_s;
      req_err_s   = addr_err(bus.req_addr);
      req_idx_s   = addr_idx(bus.req_addr);
   end

   // Next-state logic and array-read control.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      rsp_valid_nxt_s = rsp_valid_r;
      rd_en_s         = 1'b0;
      rd_idx_s        = pend_idx_r;
      rd_err_s        = pend_err_r;
      case (state_r)
         IDLE, RESP: begin
            if (accept_s) begin
               if (WAIT_STATES == 32'd0) begin
                  // Zero wait states: read on the accept edge, no bubble.
                  state_nxt_s     = RESP;
                  rsp_valid_nxt_s = 1'b1;
                  rd_en_s         = 1'b1;
                  rd_idx_s        = req_idx_s;
                  rd_err_s        = req_err_s;
               end else begin
                  state_nxt_s     = WAIT;
                  cnt_nxt_s       = 3'(WAIT_STATES);
                  rsp_valid_nxt_s = 1'b0;
               end
            end else if ((state_r == RESP) && bus.rsp_ready) begin
               state_nxt_s     = IDLE;
               rsp_valid_nxt_s = 1'b0;
            end else begin
               state_nxt_s = state_r;
            end
         end
         WAIT: begin
            cnt_nxt_s = cnt_r - 3'd1;
            if (cnt_r == 3'd1) begin
               state_nxt_s     = RESP;
               rsp_valid_nxt_s = 1'b1;
               rd_en_s         = 1'b1;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         default: begin
            state_nxt_s     = IDLE;
            cnt_nxt_s       = 3'd0;
            rsp_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State register and wait counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         cnt_r       <= 3'd0;
         rsp_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
      end
   end

   // Response registers: address/error captured at accept, data at array read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_data_r <= 32'h0000_0000;
         rsp_pc_r   <= 32'h0000_0000;
         rsp_err_r  <= 1'b0;
         pend_idx_r <= '0;
         pend_err_r <= 1'b0;
      end else begin
         if (accept_s) begin
            rsp_pc_r   <= bus.req_addr;
            rsp_err_r  <= req_err_s;
            pend_idx_r <= req_idx_s;
            pend_err_r <= req_err_s;
         end
         if (rd_en_s) begin
            rsp_data_r <= rd_err_s ? 32'h0000_0000 : mem[rd_idx_s];
         end
      end
   end

   // Side write port; a same-edge read sees the old word.
   always_ff @(posedge clk) begin
      if (load_en && !addr_err(load_addr)) begin
         mem[addr_idx(load_addr)] <= load_data;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_pc    = rsp_pc_r;
   assign bus.rsp_err   = rsp_err_r;

endmodule
